// File: rtl/xoo_pkg.sv
// Shared definitions for the Xoodyak cyclist engine and its host-side sequencer.
package xoo_pkg;

  localparam int unsigned HASH_RATE            = 16;
  localparam int unsigned DEFAULT_DIGEST_BYTES = 32;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_SHORT   = 2'd2;
  localparam logic [1:0] ERR_OVF     = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StAbsReq,
    StAbsWaitHi,
    StAbsWaitLo,
    StSqzReq,
    StSqzWaitHi,
    StSqzCollect,
    StDone
  } host_state_e;

endpackage

// File: rtl/xoo_digest_collect.sv
// Collects squeezed bytes into the digest register, first byte in the low lane.
module xoo_digest_collect #(
  parameter int unsigned DIGEST_BYTES = 32,
  parameter int unsigned CntW         = $clog2(DIGEST_BYTES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      capture,
  input  logic                      squeeze_valid,
  input  logic [7:0]                squeeze_data,
  output logic [DIGEST_BYTES*8-1:0] digest,
  output logic [CntW-1:0]           cnt_nxt,
  output logic                      ovf
);

  logic [DIGEST_BYTES*8-1:0] digest_q;
  logic [CntW-1:0]           cnt_q;
  logic                      full;
  logic                      wr;

  assign full    = (cnt_q == CntW'(DIGEST_BYTES));
  assign wr      = capture & squeeze_valid & ~full;
  // A byte arriving once the digest is full is dropped and flagged.
  assign ovf     = capture & squeeze_valid & full;
  assign cnt_nxt = cnt_q + CntW'(wr);
  assign digest  = digest_q;

  // Byte counter and digest lane write.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      digest_q <= '0;
      cnt_q    <= '0;
    end else if (wr) begin
      digest_q[{cnt_q, 3'b000} +: 8] <= squeeze_data;
      cnt_q                          <= cnt_nxt;
    end
  end

endmodule

// File: rtl/xoo_hash_host.sv
// Host sequencer: absorb request, squeeze request, digest collection and hand-off.
module xoo_hash_host
  import xoo_pkg::*;
#(
  parameter int unsigned DIGEST_BYTES   = DEFAULT_DIGEST_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [7:0]                cmd_byte,
  input  logic [15:0]               cmd_len,
  output logic                      start_absorb,
  output logic [7:0]                absorb_data,
  output logic [15:0]               absorb_len,
  output logic                      start_squeeze,
  output logic [15:0]               squeeze_len,
  input  logic [7:0]                squeeze_data,
  input  logic                      squeeze_valid,
  input  logic                      busy,
  output logic                      dig_valid,
  input  logic                      dig_ready,
  output logic [DIGEST_BYTES*8-1:0] digest,
  output logic                      err,
  output logic [1:0]                err_code
);

  localparam int unsigned CntW = $clog2(DIGEST_BYTES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  host_state_e     state_q, state_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [7:0]      absorb_data_q, absorb_data_d;
  logic [15:0]     absorb_len_q, absorb_len_d;
  logic            accept, capture, counting, tmo_hit, ovf;
  logic            raise;
  logic [1:0]      raise_code;
  logic [CntW-1:0] cnt_nxt;

  assign cmd_ready     = (state_q == StIdle) & ~rst;
  assign accept        = cmd_valid & cmd_ready;
  assign start_absorb  = (state_q == StAbsReq);
  assign start_squeeze = (state_q == StSqzReq);
  assign dig_valid     = (state_q == StDone);
  assign squeeze_len   = 16'(DIGEST_BYTES);
  assign absorb_data   = absorb_data_q;
  assign absorb_len    = absorb_len_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign capture       = (state_q == StSqzWaitHi) | (state_q == StSqzCollect);
  assign counting      = state_q inside {StAbsWaitHi, StAbsWaitLo, StSqzWaitHi, StSqzCollect};
  assign tmo_hit       = counting && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  xoo_digest_collect #(
    .DIGEST_BYTES (DIGEST_BYTES)
  ) u_collect (
    .clk           (clk),
    .rst           (rst),
    .clear         (accept),
    .capture       (capture),
    .squeeze_valid (squeeze_valid),
    .squeeze_data  (squeeze_data),
    .digest        (digest),
    .cnt_nxt       (cnt_nxt),
    .ovf           (ovf)
  );

  // Next-state, error and command-latch logic.
  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    err_code_d    = err_code_q;
    absorb_data_d = absorb_data_q;
    absorb_len_d  = absorb_len_q;
    raise         = 1'b0;
    raise_code    = ERR_NONE;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          absorb_data_d = cmd_byte;
          absorb_len_d  = cmd_len;
          err_d         = 1'b0;
          err_code_d    = ERR_NONE;
          state_d       = (cmd_len != 16'd0) ? StAbsReq : StSqzReq;
        end
      end
      StAbsReq: state_d = StAbsWaitHi;
      StAbsWaitHi: begin
        if (busy) begin
          state_d = StAbsWaitLo;
        end else if (tmo_hit) begin
          raise = 1'b1; raise_code = ERR_TIMEOUT; state_d = StDone;
        end
      end
      StAbsWaitLo: begin
        if (!busy) begin
          state_d = StSqzReq;
        end else if (tmo_hit) begin
          raise = 1'b1; raise_code = ERR_TIMEOUT; state_d = StDone;
        end
      end
      StSqzReq: state_d = StSqzWaitHi;
      StSqzWaitHi: begin
        if (busy) begin
          state_d = StSqzCollect;
        end else if (tmo_hit) begin
          raise = 1'b1; raise_code = ERR_TIMEOUT; state_d = StDone;
        end
      end
      StSqzCollect: begin
        if (ovf) begin
          raise = 1'b1; raise_code = ERR_OVF;
        end
        // Count check uses the post-capture value so a final byte with busy low still counts.
        if (!busy) begin
          state_d = StDone;
          if (cnt_nxt != CntW'(DIGEST_BYTES)) begin
            raise = 1'b1; raise_code = ERR_SHORT;
          end
        end else if (tmo_hit) begin
          raise = 1'b1; raise_code = ERR_TIMEOUT; state_d = StDone;
        end
      end
      StDone: begin
        if (dig_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // First error of a command is the one reported.
    if (raise && !err_q) begin
      err_d      = 1'b1;
      err_code_d = raise_code;
    end
  end

  // Timeout counter restarts on every state change.
  always_comb begin
    tmo_d = '0;
    if (counting && (state_d == state_q)) tmo_d = tmo_q + TmoW'(1);
  end

  // State and register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      tmo_q         <= '0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
      absorb_data_q <= '0;
      absorb_len_q  <= '0;
    end else begin
      state_q       <= state_d;
      tmo_q         <= tmo_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      absorb_data_q <= absorb_data_d;
      absorb_len_q  <= absorb_len_d;
    end
  end

endmodule

// File: tb/tb_xoo_hash_host.sv
// Randomised bench for xoo_hash_host with a behavioural engine and digest model.
module tb_xoo_hash_host;

  localparam int unsigned DB  = 32;
  localparam int unsigned TMO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [7:0]    cmd_byte = '0;
  logic [15:0]   cmd_len = '0;
  logic          cmd_ready, start_absorb, start_squeeze, dig_valid, err;
  logic [7:0]    absorb_data;
  logic [15:0]   absorb_len, squeeze_len;
  logic [7:0]    squeeze_data = '0;
  logic          squeeze_valid = 1'b0;
  logic          busy = 1'b0;
  logic          dig_ready = 1'b0;
  logic [255:0]  digest;
  logic [1:0]    err_code;

  xoo_hash_host #(
    .DIGEST_BYTES   (DB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_byte      (cmd_byte),
    .cmd_len       (cmd_len),
    .start_absorb  (start_absorb),
    .absorb_data   (absorb_data),
    .absorb_len    (absorb_len),
    .start_squeeze (start_squeeze),
    .squeeze_len   (squeeze_len),
    .squeeze_data  (squeeze_data),
    .squeeze_valid (squeeze_valid),
    .busy          (busy),
    .dig_valid     (dig_valid),
    .dig_ready     (dig_ready),
    .digest        (digest),
    .err           (err),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine configuration, written by the main sequence only.
  int         eng_nbytes   = 32;
  bit         eng_abs_busy = 1'b1;
  bit         eng_kill     = 1'b0;
  logic [7:0] eng_bytes [40];
  int         eng_emitted  = 0;

  // Behavioural engine: busy one cycle after a start, 20-cycle absorb, byte-per-cycle squeeze.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (eng_kill) begin
        busy = 1'b0; squeeze_valid = 1'b0;
      end else if (start_absorb && eng_abs_busy) begin
        @(posedge clk); #1;
        busy = 1'b1;
        repeat (20) @(posedge clk);
        #1 busy = 1'b0;
      end else if (start_squeeze) begin
        eng_emitted = 0;
        @(posedge clk); #1;
        busy = 1'b1;
        for (int i = 0; i < eng_nbytes && !eng_kill; i++) begin
          squeeze_valid = 1'b1;
          squeeze_data  = eng_bytes[i];
          eng_emitted   = i + 1;
          @(posedge clk); #1;
        end
        squeeze_valid = 1'b0;
        busy          = 1'b0;
      end
    end
  end

  // Cycle counter and start-pulse monitor.
  int          cyc = 0;
  int          abs_pulses = 0, sq_pulses = 0, sq_cyc = 0;
  logic [7:0]  abs_data_seen = '0;
  logic [15:0] abs_len_seen = '0, sq_len_seen = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (start_absorb) begin
      abs_pulses++;
      abs_data_seen = absorb_data;
      abs_len_seen  = absorb_len;
    end
    if (start_squeeze) begin
      sq_pulses++;
      sq_len_seen = squeeze_len;
      sq_cyc      = cyc;
    end
  end

  // Reference: first min(n, DB) engine bytes, remaining lanes zero.
  function automatic logic [255:0] model_digest(input int n);
    logic [255:0] d = '0;
    for (int i = 0; i < int'(DB); i++) if (i < n) d[i*8 +: 8] = eng_bytes[i];
    return d;
  endfunction

  task automatic fill_bytes(input bit ramp);
    for (int i = 0; i < 40; i++) eng_bytes[i] = ramp ? 8'(i) : 8'($urandom);
  endtask

  task automatic run_cmd(input logic [7:0] b, input logic [15:0] len, input int nbytes,
                         input bit abs_busy, input int hold);
    int           a0, s0, acc, lat;
    bit           got_done, stable_ok, tmo_case;
    logic [255:0] exp_dig, snap;
    logic [1:0]   exp_code;
    a0 = abs_pulses;
    s0 = sq_pulses;
    eng_nbytes   = nbytes;
    eng_abs_busy = abs_busy;
    eng_kill     = 1'b0;
    tmo_case     = !abs_busy && (len != 16'd0);
    if (tmo_case)          begin exp_code = 2'd1; exp_dig = '0; end
    else if (nbytes < 32)  begin exp_code = 2'd2; exp_dig = model_digest(nbytes); end
    else if (nbytes > 32)  begin exp_code = 2'd3; exp_dig = model_digest(nbytes); end
    else                   begin exp_code = 2'd0; exp_dig = model_digest(nbytes); end

    @(negedge clk);
    check_eq("cmd_ready_idle", 256'(cmd_ready), 256'(1));
    cmd_valid = 1'b1; cmd_byte = b; cmd_len = len;
    acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_byte = 8'($urandom); cmd_len = 16'($urandom);

    got_done = 1'b0;
    for (int i = 0; i < 400 && !got_done; i++) begin
      @(negedge clk);
      if (dig_valid) got_done = 1'b1;
    end
    check_eq("dig_valid_reached", 256'(got_done), 256'(1));
    if (!got_done) return;
    lat = cyc - acc;

    check_eq("busy_low_at_done", 256'(busy), 256'(0));
    check_eq("digest", digest, exp_dig);
    check_eq("err", 256'(err), 256'(exp_code != 2'd0));
    check_eq("err_code", 256'(err_code), 256'(exp_code));
    check_eq("absorb_pulses", 256'(abs_pulses - a0), 256'(len != 16'd0));
    if (len != 16'd0) begin
      check_eq("absorb_data", 256'(abs_data_seen), 256'(b));
      check_eq("absorb_len", 256'(abs_len_seen), 256'(len));
    end
    check_eq("squeeze_pulses", 256'(sq_pulses - s0), 256'(!tmo_case));
    if (!tmo_case) check_eq("squeeze_len", 256'(sq_len_seen), 256'(DB));
    if (len == 16'd0) check_eq("squeeze_after_accept", 256'(sq_cyc - acc), 256'(1));
    if (tmo_case) check_eq("timeout_latency", 256'(lat >= int'(TMO) && lat <= int'(TMO) + 4),
                           256'(1));

    snap      = digest;
    stable_ok = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (digest !== snap || cmd_ready !== 1'b0 || dig_valid !== 1'b1) stable_ok = 1'b0;
    end
    check_eq("done_hold_stable", 256'(stable_ok), 256'(1));

    dig_ready = 1'b1;
    @(posedge clk); #1;
    dig_ready = 1'b0;
    @(negedge clk);
    check_eq("dig_valid_drops", 256'(dig_valid), 256'(0));
    check_eq("back_to_idle", 256'(cmd_ready), 256'(1));
  endtask

  initial begin
    bit reached;
    int sel, nb;
    logic [15:0] len;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_ready", 256'(cmd_ready), 256'(0));
    check_eq("rst_outputs", 256'({start_absorb, start_squeeze, dig_valid, err, err_code}),
             256'(0));
    check_eq("rst_digest", digest, 256'(0));
    check_eq("rst_absorb", 256'({absorb_data, absorb_len}), 256'(0));
    check_eq("squeeze_len_const", 256'(squeeze_len), 256'(DB));
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_cmd_ready", 256'(cmd_ready), 256'(1));

    // Directed scenarios.
    fill_bytes(1'b1);
    run_cmd(8'hA5, 16'd5, 32, 1'b1, 0);
    fill_bytes(1'b0);
    run_cmd(8'h11, 16'd0, 32, 1'b1, 0);
    run_cmd(8'h22, 16'd7, 32, 1'b0, 0);
    fill_bytes(1'b0);
    run_cmd(8'h33, 16'd9, 20, 1'b1, 0);
    fill_bytes(1'b0);
    run_cmd(8'h44, 16'd3, 33, 1'b1, 0);
    fill_bytes(1'b0);
    run_cmd(8'h55, 16'd1, 32, 1'b1, 50);

    // Reset in the middle of collection.
    fill_bytes(1'b0);
    eng_nbytes = 32; eng_abs_busy = 1'b1; eng_kill = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_byte = 8'h99; cmd_len = 16'd4;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      if (eng_emitted == 11) reached = 1'b1;
    end
    check_eq("mid_collect_reached", 256'(reached), 256'(1));
    rst = 1'b1; eng_kill = 1'b1;
    @(negedge clk);
    check_eq("midrst_outputs", 256'({cmd_ready, start_absorb, start_squeeze, dig_valid, err,
                                     err_code}), 256'(0));
    check_eq("midrst_digest", digest, 256'(0));
    check_eq("midrst_absorb", 256'({absorb_data, absorb_len}), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_idle", 256'(cmd_ready), 256'(1));
    fill_bytes(1'b0);
    run_cmd(8'h3C, 16'd16, 32, 1'b1, 0);

    // Randomised commands.
    for (int t = 0; t < 8; t++) begin
      fill_bytes(1'b0);
      sel = $urandom_range(0, 2);
      nb  = (sel == 0) ? 32 : (sel == 1) ? $urandom_range(20, 31) : $urandom_range(33, 36);
      len = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      run_cmd(8'($urandom), len, nb, 1'b1, $urandom_range(0, 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xoo_hash_host.md
Name: xoo_hash_host

Overview:
- Host-side sequencer for the Xoodyak cyclist hash engine; it is the initiator that drives the engine's absorb/squeeze command interface and consumes its squeeze byte stream.
- Accepts one hash command (fill byte + message length) on a valid/ready port.
- Issues an absorb request, then a squeeze request, and collects the squeezed bytes into a digest register.
- Presents the digest downstream with a valid/ready handshake and flags protocol errors and timeouts.

Parameters:
- DIGEST_BYTES, 32, number of bytes requested via squeeze_len and collected into digest.
- TIMEOUT_CYCLES, 65535, maximum cycles spent waiting for any single engine busy edge before an error is raised.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_byte  in  8  message fill byte, forwarded as absorb_data
- cmd_len  in  16  message length in bytes, forwarded as absorb_len
- start_absorb  out  1  one-cycle absorb request to engine
- absorb_data  out  8  registered copy of cmd_byte
- absorb_len  out  16  registered copy of cmd_len
- start_squeeze  out  1  one-cycle squeeze request to engine
- squeeze_len  out  16  constant DIGEST_BYTES
- squeeze_data  in  8  engine output byte
- squeeze_valid  in  1  squeeze_data qualifier
- busy  in  1  engine busy
- dig_valid  out  1  digest available
- dig_ready  in  1  digest consumed
- digest  out  DIGEST_BYTES*8  collected bytes; first byte in [7:0]
- err  out  1  error flag, sticky until the next accepted command
- err_code  out  2  0 none, 1 busy timeout, 2 short squeeze, 3 overflow

Behaviour:
- Reset values:
  - cmd_ready=0 during reset, then 1 in IDLE.
  - start_absorb, start_squeeze, dig_valid and err are 0.
  - err_code=0, digest=0, absorb_data=0, absorb_len=0.
  - State goes to IDLE; byte and timeout counters clear.
  - Reset overrides every state, including mid-collection; partial digest contents are discarded to 0.
- State machine:
  - IDLE, ABS_REQ, ABS_WAIT_HI, ABS_WAIT_LO, SQZ_REQ, SQZ_WAIT_HI, SQZ_COLLECT, DONE.
- IDLE:
  - The command is accepted when cmd_valid & cmd_ready. On acceptance: latch cmd_byte/cmd_len, clear err/err_code/digest/counters.
  - If cmd_len != 0, go to ABS_REQ; otherwise go to SQZ_REQ (the absorb phase is skipped).
- ABS_REQ:
  - start_absorb=1 for exactly this one cycle.
  - absorb_data/absorb_len are held stable from acceptance until DONE.
  - Next state is ABS_WAIT_HI.
- ABS_WAIT_HI: wait for busy=1, then go to ABS_WAIT_LO.
- ABS_WAIT_LO: wait for busy=0, then go to SQZ_REQ.
- SQZ_REQ: start_squeeze=1 for one cycle, then go to SQZ_WAIT_HI.
- SQZ_WAIT_HI: wait for busy=1, then go to SQZ_COLLECT.
  - A squeeze_valid seen in this state is also captured.
- SQZ_COLLECT:
  - Each cycle with squeeze_valid=1 writes squeeze_data to digest[cnt*8 +: 8] and increments cnt.
  - cnt is clog2(DIGEST_BYTES+1) bits wide.
  - When busy=0 and cnt==DIGEST_BYTES, go to DONE.
  - Capture and the busy-low check in the same cycle: the byte is captured first, then the count is checked.
- Timeout:
  - The counter clears on every state change and counts in each WAIT state and in SQZ_COLLECT.
  - When it reaches TIMEOUT_CYCLES: err=1, err_code=1, go to DONE.
- Short squeeze: busy=0 in SQZ_COLLECT with cnt<DIGEST_BYTES sets err=1, err_code=2, and goes to DONE.
- Overflow:
  - squeeze_valid when cnt==DIGEST_BYTES sets err=1, err_code=3; the byte is dropped.
  - Collection continues until busy=0.
- DONE:
  - dig_valid=1; digest and err are stable.
  - dig_valid & dig_ready returns to IDLE; dig_valid drops the next cycle.
  - cmd_ready is 0 until IDLE is reached, so there is no command/digest overlap.
- Minimum latency, cmd_len=0 with an instant-busy engine: about DIGEST_BYTES+4 cycles from acceptance to dig_valid.
- cmd_valid is ignored outside IDLE.

Decomposition:
- Shared package xoo_pkg holds:
  - the state enum;
  - err_code constants ERR_NONE/ERR_TIMEOUT/ERR_SHORT/ERR_OVF;
  - HASH_RATE=16 and DEFAULT_DIGEST_BYTES=32, shared with the cyclist.
- One natural sub-module: xoo_digest_collect (byte counter, digest write, overflow detect).
- The FSM and timeout counter stay in the top module.

Test Plan:
- Behavioural engine model: busy rises 1 cycle after a start pulse, absorb busy lasts 20 cycles, squeeze emits bytes 0x00..0x1F on consecutive cycles and then drops busy.
  - Command byte 0xA5, len 5 → exactly one start_absorb pulse with absorb_data=0xA5, absorb_len=5.
  - Then one start_squeeze pulse with squeeze_len=32.
  - digest[7:0]=0x00, digest[255:248]=0x1F, dig_valid=1, err=0.
- cmd_len=0 → no start_absorb pulse, start_squeeze follows acceptance by 1 cycle, digest correct.
- Engine never raises busy after start_absorb, with TIMEOUT_CYCLES=100 → dig_valid at ~cycle 102, err=1, err_code=1.
- Engine emits 20 bytes then drops busy → err_code=2, digest bytes 20..31 = 0.
- Engine emits 33 bytes → err_code=3, the 33rd byte is not stored, dig_valid rises only after busy=0.
- Pulse rst for 1 cycle mid-SQZ_COLLECT (cnt=10) → all outputs at reset values next cycle.
  - A new command (0x3C, len 16) then completes normally.
- Hold dig_ready=0 for 50 cycles in DONE → digest stable, cmd_ready=0; the handshake then returns to IDLE.
